// File: rtl/matmul_scheduler_if.sv
// Control and buffer-port bundle for matmul_scheduler: start/status toward the top-level FSM,
// read ports toward the A/B operand buffers and the write port toward the C result buffer.
interface matmul_scheduler_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic [3:0]        matrix_size;
    logic              a_rd_en;
    logic [ADDR_W-1:0] a_rd_addr;
    logic [DATA_W-1:0] a_rd_data;
    logic              b_rd_en;
    logic [ADDR_W-1:0] b_rd_addr;
    logic [DATA_W-1:0] b_rd_data;
    logic              c_wr_en;
    logic [ADDR_W-1:0] c_wr_addr;
    logic [15:0]       c_wr_data;
    logic              busy;
    logic              done;
    logic              size_err;

    // master: the scheduler itself
    modport master (
        input  start, matrix_size, a_rd_data, b_rd_data,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output c_wr_en, c_wr_addr, c_wr_data, busy, done, size_err
    );

    // slave: control FSM plus operand/result memories
    modport slave (
        output start, matrix_size, a_rd_data, b_rd_data,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  c_wr_en, c_wr_addr, c_wr_data, busy, done, size_err
    );
endinterface

// File: rtl/matmul_scheduler.sv
// Walks (i, j, k) for an N x N product, issuing A/B reads and C writes on a fixed schedule.
// Optional MATMUL_SATURATE_EN clamps C elements to 16'hFFFF instead of wrapping.
module matmul_scheduler #(
    parameter int unsigned MAX_N  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned ADDR_W = 6
) (
    input logic clk,
    input logic rst,
    matmul_scheduler_if.master bus
);
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {StIdle, StFetch, StAcc, StWrite, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [3:0]        n_q, i_q, j_q, k_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic [15:0]       c_data_q;

    logic              size_ok, last_i, last_j, last_k;
    logic [PROD_W-1:0] prod;
    logic [ADDR_W-1:0] c_addr_cur;
    logic [15:0]       c_res;

    assign size_ok    = (bus.matrix_size != 4'd0) && (bus.matrix_size <= 4'(MAX_N));
    assign last_i     = (i_q == n_q - 4'd1);
    assign last_j     = (j_q == n_q - 4'd1);
    assign last_k     = (k_q == n_q - 4'd1);
    assign prod       = PROD_W'(bus.a_rd_data) * PROD_W'(bus.b_rd_data);
    assign c_addr_cur = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(j_q);

`ifdef MATMUL_SATURATE_EN
    assign c_res = (acc_q > ACC_W'(16'hFFFF)) ? 16'hFFFF : acc_q[15:0];
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc_q[ACC_W-1:16];
    assign c_res         = acc_q[15:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = size_ok ? StFetch : StErr;
            StFetch: if (last_k) state_d = StAcc;
            StAcc:   state_d = StWrite;
            StWrite: state_d = (last_i && last_j) ? StDone : StFetch;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.a_rd_en   = 1'b0;
        bus.b_rd_en   = 1'b0;
        bus.a_rd_addr = '0;
        bus.b_rd_addr = '0;
        bus.c_wr_en   = 1'b0;
        bus.c_wr_addr = c_addr_q;
        bus.c_wr_data = c_data_q;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.size_err  = 1'b0;
        unique case (state_q)
            StFetch: begin
                bus.a_rd_en   = 1'b1;
                bus.b_rd_en   = 1'b1;
                bus.a_rd_addr = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(k_q);
                bus.b_rd_addr = ADDR_W'(k_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
                bus.busy      = 1'b1;
            end
            StAcc:   bus.busy = 1'b1;
            StWrite: begin
                bus.c_wr_en   = 1'b1;
                bus.c_wr_addr = c_addr_cur;
                bus.c_wr_data = c_res;
                bus.busy      = 1'b1;
            end
            StDone: begin
                bus.done = 1'b1;
                bus.busy = 1'b1;
            end
            StErr:   bus.size_err = 1'b1;
            default: ;
        endcase
    end

    // Each FETCH cycle folds in the product of the previous cycle's reads; ACC folds the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            c_addr_q <= '0;
            c_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && size_ok) begin
                        n_q <= bus.matrix_size;
                        i_q <= '0;
                        j_q <= '0;
                        k_q <= '0;
                    end
                end
                StFetch: begin
                    acc_q <= (k_q == 4'd0) ? '0 : acc_q + ACC_W'(prod);
                    k_q   <= last_k ? 4'd0 : k_q + 4'd1;
                end
                StAcc: acc_q <= acc_q + ACC_W'(prod);
                StWrite: begin
                    c_addr_q <= c_addr_cur;
                    c_data_q <= c_res;
                    if (last_j) begin
                        j_q <= '0;
                        i_q <= last_i ? 4'd0 : i_q + 4'd1;
                    end else begin
                        j_q <= j_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_scheduler.sv
// Self-checking bench for matmul_scheduler: registered-read operand memories, a write/event
// monitor, and a reference model computing C = A x B directly from the stored matrices.
module tb_matmul_scheduler;
    localparam int MAX_N  = 8;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    matmul_scheduler #(
        .MAX_N (MAX_N),
        .DATA_W(DATA_W),
        .ACC_W (20),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] a_mem[64];
    logic [7:0] b_mem[64];

    // Operand buffers with one-cycle registered read latency
    always @(posedge clk) begin
        if (bus.a_rd_en) bus.a_rd_data <= a_mem[bus.a_rd_addr];
        if (bus.b_rd_en) bus.b_rd_data <= b_mem[bus.b_rd_addr];
    end

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    int          t_accept = 0;
    int          a_reads, b_reads, done_cnt, err_cnt, busy_cnt, done_rel;
    logic [5:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    always @(negedge clk) begin
        if (bus.c_wr_en) begin
            wr_addr_q.push_back(bus.c_wr_addr);
            wr_data_q.push_back(bus.c_wr_data);
        end
        if (bus.a_rd_en) a_reads++;
        if (bus.b_rd_en) b_reads++;
        if (bus.size_err) err_cnt++;
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
            done_cnt++;
            done_rel = pcyc - t_accept + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic clear_stats();
        a_reads  = 0;
        b_reads  = 0;
        done_cnt = 0;
        err_cnt  = 0;
        busy_cnt = 0;
        done_rel = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    function automatic logic [15:0] ref_c(int n, int i, int j);
        longint s = 0;
        for (int k = 0; k < n; k++) s += int'(a_mem[i * n + k]) * int'(b_mem[k * n + j]);
`ifdef MATMUL_SATURATE_EN
        return (s > 65535) ? 16'hFFFF : 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    task automatic fill_random();
        for (int x = 0; x < 64; x++) begin
            a_mem[x] = 8'($urandom);
            b_mem[x] = 8'($urandom);
        end
    endtask

    // Entered and left at posedge+2 with the DUT idle.
    task automatic run_job(input int n, input bit disturb, input bit chk_idle, input string name);
        int to;
        int exp_cyc;
        int nw;
        exp_cyc = n * n * (n + 2) + 1;
        clear_stats();
        bus.start       = 1'b1;
        bus.matrix_size = 4'(n);
        t_accept        = pcyc + 1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        to = 0;
        while (to < 2000) begin
            @(posedge clk);
            #2;
            to++;
            if (done_cnt != 0) break;
            if (disturb) begin
                bus.start       = ($urandom_range(0, 2) == 0);
                bus.matrix_size = 4'($urandom_range(0, 15));
            end
        end
        bus.start = 1'b0;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done_seen: got %0d done pulses, want 1", name, done_cnt);
        end
        checks++;
        if (done_rel != exp_cyc) begin
            errors++;
            $display("FAIL %s_done_cycle: got %0d want %0d", name, done_rel, exp_cyc);
        end
        checks++;
        if (busy_cnt != exp_cyc) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cnt, exp_cyc);
        end
        checks++;
        if (a_reads != n * n * n || b_reads != n * n * n) begin
            errors++;
            $display("FAIL %s_reads: got a=%0d b=%0d want %0d", name, a_reads, b_reads, n * n * n);
        end
        nw = wr_addr_q.size();
        checks++;
        if (nw != n * n) begin
            errors++;
            $display("FAIL %s_write_count: got %0d want %0d", name, nw, n * n);
        end
        for (int e = 0; e < nw && e < n * n; e++) begin
            checks++;
            if (wr_addr_q[e] !== 6'(e) || wr_data_q[e] !== ref_c(n, e / n, e % n)) begin
                errors++;
                $display("FAIL %s_write[%0d]: got (%0d,%h) want (%0d,%h)", name, e, wr_addr_q[e],
                         wr_data_q[e], e, ref_c(n, e / n, e % n));
            end
        end
        if (chk_idle) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                errors++;
                $display("FAIL %s_idle_after: got busy/done=%b want 00", name, {bus.busy, bus.done});
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.matrix_size = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.a_rd_en, bus.b_rd_en, bus.c_wr_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000", {bus.a_rd_en, bus.b_rd_en, bus.c_wr_en});
        end
        checks++;
        if ({bus.a_rd_addr, bus.b_rd_addr, bus.c_wr_addr} !== 18'd0) begin
            errors++;
            $display("FAIL reset_addrs: got %h want 0", {bus.a_rd_addr, bus.b_rd_addr, bus.c_wr_addr});
        end
        checks++;
        if (bus.c_wr_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_wdata: got %h want 0000", bus.c_wr_data);
        end
        checks++;
        if ({bus.busy, bus.done, bus.size_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.size_err});
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic test_n2_example();
        logic [15:0] exp_c[4];
        exp_c = '{16'd19, 16'd22, 16'd43, 16'd50};
        a_mem[0] = 8'd1; a_mem[1] = 8'd2; a_mem[2] = 8'd3; a_mem[3] = 8'd4;
        b_mem[0] = 8'd5; b_mem[1] = 8'd6; b_mem[2] = 8'd7; b_mem[3] = 8'd8;
        run_job(2, 1'b0, 1'b1, "n2");
        for (int e = 0; e < 4 && e < wr_data_q.size(); e++) begin
            checks++;
            if (wr_data_q[e] !== exp_c[e]) begin
                errors++;
                $display("FAIL n2_const[%0d]: got %0d want %0d", e, wr_data_q[e], exp_c[e]);
            end
        end
    endtask

    task automatic test_n1();
        a_mem[0] = 8'd3;
        b_mem[0] = 8'd4;
        run_job(1, 1'b0, 1'b1, "n1");
        checks++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== 16'd12) begin
            errors++;
            $display("FAIL n1_const: got %0d writes, first %0d, want one write of 12",
                     wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 16'd0);
        end
    endtask

    task automatic test_size_err();
        int sizes[3];
        sizes = '{0, 9, 15};
        for (int s = 0; s < 3; s++) begin
            clear_stats();
            bus.start       = 1'b1;
            bus.matrix_size = 4'(sizes[s]);
            @(posedge clk);
            #2;
            bus.start = 1'b0;
            repeat (4) begin
                @(posedge clk);
                #2;
            end
            checks++;
            if (err_cnt != 1) begin
                errors++;
                $display("FAIL size_err_pulse[%0d]: got %0d cycles want 1", sizes[s], err_cnt);
            end
            checks++;
            if (a_reads != 0 || b_reads != 0 || wr_addr_q.size() != 0) begin
                errors++;
                $display("FAIL size_err_quiet[%0d]: got reads=%0d writes=%0d want 0", sizes[s],
                         a_reads, wr_addr_q.size());
            end
            checks++;
            if (busy_cnt != 0 || done_cnt != 0) begin
                errors++;
                $display("FAIL size_err_busy[%0d]: got busy=%0d done=%0d want 0", sizes[s],
                         busy_cnt, done_cnt);
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_v;
`ifdef MATMUL_SATURATE_EN
        exp_v = 16'hFFFF;
`else
        exp_v = 16'hF008;
`endif
        for (int x = 0; x < 64; x++) begin
            a_mem[x] = 8'hFF;
            b_mem[x] = 8'hFF;
        end
        run_job(8, 1'b0, 1'b1, "n8_full");
        checks++;
        if (wr_data_q.size() != 64 || wr_data_q[63] !== exp_v) begin
            errors++;
            $display("FAIL n8_full_const: got %0d writes, last %h, want 64 writes of %h",
                     wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[$] : 16'h0, exp_v);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_job(int'($urandom_range(1, MAX_N)), 1'b0, 1'b1, "random");
        end
    endtask

    task automatic test_mid_reset();
        fill_random();
        clear_stats();
        bus.start       = 1'b1;
        bus.matrix_size = 4'd2;
        t_accept        = pcyc + 1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.a_rd_en, bus.b_rd_en, bus.c_wr_en, bus.busy, bus.done, bus.size_err} !== 6'd0 ||
            {bus.a_rd_addr, bus.b_rd_addr, bus.c_wr_addr} !== 18'd0 || bus.c_wr_data !== 16'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got strobes/flags=%b addrs=%h data=%h want all 0",
                     {bus.a_rd_en, bus.b_rd_en, bus.c_wr_en, bus.busy, bus.done, bus.size_err},
                     {bus.a_rd_addr, bus.b_rd_addr, bus.c_wr_addr}, bus.c_wr_data);
        end
        checks++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== ref_c(2, 0, 0)) begin
            errors++;
            $display("FAIL midrst_partial: got %0d writes want 1 of %h", wr_data_q.size(),
                     ref_c(2, 0, 0));
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_stats();
        repeat (12) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (a_reads != 0 || wr_addr_q.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL midrst_quiet: got reads=%0d writes=%0d done=%0d want 0", a_reads,
                     wr_addr_q.size(), done_cnt);
        end
        fill_random();
        run_job(2, 1'b0, 1'b1, "midrst_fresh");
    endtask

    task automatic test_disturb();
        fill_random();
        run_job(2, 1'b1, 1'b1, "disturb");
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_job(2, 1'b0, 1'b0, "b2b_first");
        run_job(3, 1'b0, 1'b1, "b2b_second");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_stats();
        test_reset();
        test_n2_example();
        test_n1();
        test_size_err();
        test_saturate();
        test_random();
        test_mid_reset();
        test_disturb();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
